// File: rtl/ps2_dev_tx.sv
// Buffered PS/2 device-side transmitter: byte FIFO feeding an 11-bit open-drain
// frame serialiser that backs off on host inhibit or request-to-send.
module ps2_dev_tx #(
    parameter int CLK         = 50000000,
    parameter int FREQUENCY   = 12000,
    parameter int FIFO_DEPTH  = 8,
    parameter int HOLDOFF_US  = 50,
    // Derived from HOLDOFF_US; overridable because the integer formula collapses below 1 MHz.
    parameter int HOLDOFF_CYC = CLK / 1000000 * HOLDOFF_US
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          ps2_clk_in,
    input  logic                          ps2_data_in,
    output logic                          ps2_clk_oe,
    output logic                          ps2_data_oe,
    output logic                          busy,
    output logic                          aborted,
    output logic [$clog2(FIFO_DEPTH):0]   level
);
    localparam int DIV  = CLK / FREQUENCY;
    localparam int HALF = DIV / 2;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int LW   = AW + 1;
    localparam int CW   = $clog2(DIV);
    localparam int HCYC = (HOLDOFF_CYC < 1) ? 1 : HOLDOFF_CYC;
    localparam int HW   = $clog2(HCYC + 1);

    localparam logic [CW-1:0] CNT_LAST   = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_HALF   = CW'(HALF);
    localparam logic [CW-1:0] CNT_CHK_LO = CW'(3);
    localparam logic [CW-1:0] CNT_CHK_HI = CW'(HALF - 1);
    localparam logic [HW-1:0] HCNT_LAST  = HW'(HCYC - 1);
    localparam logic [LW-1:0] LVL_FULL   = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] LVL_ONE    = LW'(1);

    typedef enum logic [1:0] {IDLE, HOLDOFF, SEND, ABORT} state_t;

    state_t          state;
    logic [1:0]      clk_sync, data_sync;
    logic            clk_s, data_s;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [7:0]      head;
    logic [10:0]     frame;
    logic [3:0]      bit_idx, next_idx;
    logic [CW-1:0]   bitcnt, cnt_nxt;
    logic [HW-1:0]   hcnt;
    logic            push, pop, inhibit;

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk_in};
            data_sync <= {data_sync[0], ps2_data_in};
        end
    end
    assign clk_s  = clk_sync[1];
    assign data_s = data_sync[1];

    assign in_ready = (level != LVL_FULL);
    assign push     = in_valid && in_ready;
    assign busy     = (state != IDLE) || (level != '0);
    assign head     = mem[rd_ptr];
    assign frame    = {1'b1, ~^head, head, 1'b0};
    assign next_idx = bit_idx + 4'd1;
    assign cnt_nxt  = bitcnt + 1'b1;

    // Head byte leaves only once its stop bit has fully elapsed; aborts keep it for retry.
    assign pop = (state == SEND) && (bit_idx == 4'd10) && (bitcnt == CNT_LAST);

    // Host clock low during our released phase; skip the first cycles to cover sync latency.
    assign inhibit = (state == SEND) && (bit_idx <= 4'd9) && !clk_s &&
                     (bitcnt >= CNT_CHK_LO) && (bitcnt <= CNT_CHK_HI);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            bit_idx     <= '0;
            bitcnt      <= '0;
            hcnt        <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            aborted     <= 1'b0;
        end else begin
            aborted <= 1'b0;
            case (state)
                IDLE: begin
                    if (level != '0) begin
                        state <= HOLDOFF;
                        hcnt  <= '0;
                    end
                end
                HOLDOFF: begin
                    if (clk_s && data_s) begin
                        if (hcnt == HCNT_LAST) begin
                            state       <= SEND;
                            bit_idx     <= '0;
                            bitcnt      <= '0;
                            ps2_data_oe <= 1'b1;
                            ps2_clk_oe  <= 1'b0;
                        end else begin
                            hcnt <= hcnt + 1'b1;
                        end
                    end else begin
                        hcnt <= '0;
                    end
                end
                SEND: begin
                    if (inhibit) begin
                        state       <= ABORT;
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        aborted     <= 1'b1;
                    end else if (bitcnt == CNT_LAST) begin
                        ps2_clk_oe <= 1'b0;
                        bitcnt     <= '0;
                        if (bit_idx == 4'd10) begin
                            ps2_data_oe <= 1'b0;
                            hcnt        <= '0;
                            state       <= ((level != LVL_ONE) || push) ? HOLDOFF : IDLE;
                        end else begin
                            bit_idx     <= next_idx;
                            ps2_data_oe <= ~frame[next_idx];
                        end
                    end else begin
                        bitcnt     <= cnt_nxt;
                        ps2_clk_oe <= (cnt_nxt >= CNT_HALF);
                    end
                end
                ABORT: begin
                    state <= HOLDOFF;
                    hcnt  <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/ps2_dev_tx.md
Name: ps2_dev_tx

Overview:
- Buffered, parametrised PS/2 device-side transmitter; the next generation of the single-byte PS/2 transmitter.
- Accepts bytes through a valid/ready FIFO and serialises each as an 11-bit PS/2 frame onto open-drain clock and data lines.
- Monitors the bus for host inhibit (clock held low) and request-to-send (data low), aborting and retrying frames as needed.
- Sits between the UART-to-PS/2 bridge logic and the board PS/2 pins.

Parameters:
CLK, 50000000, system clock frequency in Hz
FREQUENCY, 12000, PS/2 bit rate in Hz; CLK_DIVISOR = CLK/FREQUENCY, must be >= 12
FIFO_DEPTH, 8, byte buffer entries; power of two, >= 2
HOLDOFF_US, 50, idle bus time in microseconds required before starting or retrying a frame; HOLDOFF_CYC = CLK/1000000*HOLDOFF_US

Ports:
clk  in  1  system clock, sole clock domain
reset  in  1  synchronous, active-high reset
in_data  in  8  byte to transmit
in_valid  in  1  byte offered
in_ready  out  1  FIFO not full; push occurs when in_valid && in_ready
ps2_clk_in  in  1  PS/2 clock pin state, asynchronous
ps2_data_in  in  1  PS/2 data pin state, asynchronous
ps2_clk_oe  out  1  1 = pull clock line low, 0 = release
ps2_data_oe  out  1  1 = pull data line low, 0 = release
busy  out  1  frame in progress or FIFO non-empty
aborted  out  1  one-cycle pulse when a frame is aborted by host inhibit
level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (synchronous, active-high): FIFO empties; state <= IDLE; ps2_clk_oe = 0, ps2_data_oe = 0, in_ready = 1, busy = 0, aborted = 0, level = 0. Reset mid-frame releases both lines on the next edge; the partial frame is discarded.
- Synchroniser: ps2_clk_in and ps2_data_in each pass through 2 flops; all bus decisions use the synced values.
- FIFO: push and pop in the same cycle leave level unchanged. When full, in_ready = 0 and pushes are ignored. Pointers wrap modulo FIFO_DEPTH. The head byte is popped only on successful frame completion.
- Frame: start bit 0, data[0..7] LSB first, odd parity (~^data), stop bit 1.
- Bit timing: each bit lasts CLK_DIVISOR cycles, counted by bitcnt from 0 to CLK_DIVISOR-1.
  - ps2_data_oe = ~bit for the whole bit.
  - ps2_clk_oe = 0 for bitcnt < CLK_DIVISOR/2 and 1 for bitcnt >= CLK_DIVISOR/2.
  - Frame length = 11*CLK_DIVISOR cycles.
- States:
  - IDLE: both lines released. When the FIFO is non-empty, go to HOLDOFF.
  - HOLDOFF: count cycles while synced clk = 1 and synced data = 1; any 0 restarts the count. After HOLDOFF_CYC consecutive idle cycles, go to SEND with bit index 0 and bitcnt 0.
  - SEND: drive bits 0..10. After bit 10 ends (bitcnt = CLK_DIVISOR-1): pop the FIFO, release the lines, return to IDLE (or HOLDOFF if the FIFO is still non-empty).
  - ABORT: release both lines for one cycle, pulse aborted, go to HOLDOFF.
- Inhibit check: in SEND, during bit indices 0..9, when bitcnt is in [3, CLK_DIVISOR/2-1] (released phase after synchroniser latency), synced clk = 0 means host inhibit, and the next state is ABORT. The byte stays at the FIFO head and is retried.
  - Inhibit during bit 10 (stop) is ignored; the frame counts as delivered.
- busy = (state != IDLE) || (level != 0).
- Bytes pushed during a frame do not disturb the frame in progress.

Test Plan:
Use CLK=1200, FREQUENCY=100 (CLK_DIVISOR=12), HOLDOFF_US chosen so HOLDOFF_CYC=4, FIFO_DEPTH=4, bus modelled as pull-ups.
- Single byte 0xA5, bus idle -> send starts 4 cycles after the push is seen. The data line carries 0,1,0,1,0,0,1,0,1, parity 1, stop 1; each clock-low phase is 6 cycles; total 132 cycles; then busy = 0 and level = 0.
- Push 0x00, 0xFF, 0x12, 0x34 back-to-back -> level = 4 and in_ready = 0. A 5th push (0x56) is ignored. Frames appear in order: 0x00 with parity 1, 0xFF with parity 1, 0x12 with parity 1, 0x34 with parity 0; each is separated by >= 4 idle cycles.
- Host holds clock low during the released half of bit 4 of 0x3C -> aborted pulses once and both lines are released. After the clock has been high for 4 cycles, 0x3C is resent in full from the start bit; level decrements only after the resend.
- Host pulls clock low during the stop bit -> no abort; the byte is popped.
- Host holds data low (request-to-send) while a byte is queued -> the frame does not start until data has been high for 4 consecutive cycles.
- Reset asserted at bit 6 of a frame with 2 bytes queued -> next cycle both oe = 0, level = 0, busy = 0, in_ready = 1, and no further frame is sent.
